// File: rtl/regfile_wb_scheduler.sv
// regfile_wb_scheduler: scoreboard and write-port scheduler for the 32x32
// register file. Tracks outstanding writebacks, blocks RAW/WAW hazards at
// issue, and round-robin arbitrates ALU/load writebacks onto one write port.
//
// Ports:
//   clk, reset         clock, asynchronous active-high reset
//   issue_*            decode-side instruction (rs1, rs2, rd, rd_we, valid)
//   issue_ready        no hazard against the scoreboard (ignores valid)
//   alu_wb_*, ld_wb_*  writeback requests; *_ready is the grant this cycle
//   rf_we/waddr/wdata  register file write port, one cycle after the grant
//   busy_vec           scoreboard, bit i = write to xi outstanding
//   stall_count        saturating count of cycles with valid & !ready
module regfile_wb_scheduler #(
    parameter int XLEN = 32,
    parameter int NREG = 32,
    parameter int AW   = 5,
    parameter int SCW  = 16
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            issue_valid,
    input  logic [AW-1:0]   issue_rs1,
    input  logic [AW-1:0]   issue_rs2,
    input  logic [AW-1:0]   issue_rd,
    input  logic            issue_rd_we,
    output logic            issue_ready,
    input  logic            alu_wb_valid,
    input  logic [AW-1:0]   alu_wb_rd,
    input  logic [XLEN-1:0] alu_wb_data,
    output logic            alu_wb_ready,
    input  logic            ld_wb_valid,
    input  logic [AW-1:0]   ld_wb_rd,
    input  logic [XLEN-1:0] ld_wb_data,
    output logic            ld_wb_ready,
    output logic            rf_we,
    output logic [AW-1:0]   rf_waddr,
    output logic [XLEN-1:0] rf_wdata,
    output logic [NREG-1:0] busy_vec,
    output logic [SCW-1:0]  stall_count
);

    logic [NREG-1:0] busy_q, busy_d;
    logic            last_grant_q, last_grant_d;
    logic            ws_valid_q, ws_valid_d;
    logic [AW-1:0]   ws_rd_q, ws_rd_d;
    logic [XLEN-1:0] ws_data_q, ws_data_d;
    logic [SCW-1:0]  stall_q, stall_d;

    logic hazard;
    logic issue_acc;
    logic alu_gnt;
    logic ld_gnt;

    always_comb begin
        hazard = busy_q[issue_rs1]
               | busy_q[issue_rs2]
               | (issue_rd_we & busy_q[issue_rd]);
        issue_ready = !hazard;
        issue_acc   = issue_valid & !hazard;
    end

    // last_grant_q: 0 = ALU got the last grant, 1 = load did.
    always_comb begin
        alu_gnt = 1'b0;
        ld_gnt  = 1'b0;
        case ({alu_wb_valid, ld_wb_valid})
            2'b11: begin
                if (last_grant_q) alu_gnt = 1'b1;
                else              ld_gnt  = 1'b1;
            end
            2'b10:   alu_gnt = 1'b1;
            2'b01:   ld_gnt  = 1'b1;
            default: ;
        endcase
        alu_wb_ready = alu_gnt;
        ld_wb_ready  = ld_gnt;
    end

    always_comb begin
        last_grant_d = last_grant_q;
        ws_valid_d   = alu_gnt | ld_gnt;
        ws_rd_d      = ws_rd_q;
        ws_data_d    = ws_data_q;
        if (alu_gnt) begin
            last_grant_d = 1'b0;
            ws_rd_d      = alu_wb_rd;
            ws_data_d    = alu_wb_data;
        end
        if (ld_gnt) begin
            last_grant_d = 1'b1;
            ws_rd_d      = ld_wb_rd;
            ws_data_d    = ld_wb_data;
        end
    end

    // Clear on commit, then set on issue, so a same-edge set wins.
    always_comb begin
        busy_d = busy_q;
        if (ws_valid_q) busy_d[ws_rd_q] = 1'b0;
        if (issue_acc && issue_rd_we && (issue_rd != '0))
            busy_d[issue_rd] = 1'b1;
        busy_d[0] = 1'b0;
    end

    always_comb begin
        stall_d = stall_q;
        if (issue_valid && hazard && (stall_q != {SCW{1'b1}}))
            stall_d = stall_q + SCW'(1);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy_q       <= '0;
            last_grant_q <= 1'b1;
            ws_valid_q   <= 1'b0;
            ws_rd_q      <= '0;
            ws_data_q    <= '0;
            stall_q      <= '0;
        end else begin
            busy_q       <= busy_d;
            last_grant_q <= last_grant_d;
            ws_valid_q   <= ws_valid_d;
            ws_rd_q      <= ws_rd_d;
            ws_data_q    <= ws_data_d;
            stall_q      <= stall_d;
        end
    end

    // x0 writes are accepted and consumed but never reach the file.
    always_comb begin
        rf_we       = ws_valid_q & (ws_rd_q != '0);
        rf_waddr    = ws_rd_q;
        rf_wdata    = ws_data_q;
        busy_vec    = busy_q;
        stall_count = stall_q;
    end

endmodule

// File: tb/tb_regfile_wb_scheduler.sv
// Testbench for regfile_wb_scheduler: reference model plus write scoreboard.
// Directed scenarios, counter saturation, then randomized traffic.
module tb_regfile_wb_scheduler;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        issue_valid;
    logic [4:0]  issue_rs1, issue_rs2, issue_rd;
    logic        issue_rd_we;
    logic        issue_ready;
    logic        alu_wb_valid;
    logic [4:0]  alu_wb_rd;
    logic [31:0] alu_wb_data;
    logic        alu_wb_ready;
    logic        ld_wb_valid;
    logic [4:0]  ld_wb_rd;
    logic [31:0] ld_wb_data;
    logic        ld_wb_ready;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic [31:0] busy_vec;
    logic [15:0] stall_count;

    regfile_wb_scheduler dut (
        .clk(clk), .reset(reset),
        .issue_valid(issue_valid), .issue_rs1(issue_rs1),
        .issue_rs2(issue_rs2), .issue_rd(issue_rd),
        .issue_rd_we(issue_rd_we), .issue_ready(issue_ready),
        .alu_wb_valid(alu_wb_valid), .alu_wb_rd(alu_wb_rd),
        .alu_wb_data(alu_wb_data), .alu_wb_ready(alu_wb_ready),
        .ld_wb_valid(ld_wb_valid), .ld_wb_rd(ld_wb_rd),
        .ld_wb_data(ld_wb_data), .ld_wb_ready(ld_wb_ready),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .busy_vec(busy_vec), .stall_count(stall_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          cyc;
        logic [4:0]  rd;
        logic [31:0] data;
    } wr_t;

    wr_t sb[$];
    wr_t clr_q[$];
    bit  m_busy[32];
    bit  m_last;
    int  m_stall;
    int  cyc = 0;
    int  n_checks = 0;
    int  n_fail = 0;
    bit  g_alu, g_ld;

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)",
                     name, act, exp, cyc);
        end
    endtask

    task automatic set_idle();
        issue_valid  = 1'b0;
        issue_rs1    = '0;
        issue_rs2    = '0;
        issue_rd     = '0;
        issue_rd_we  = 1'b0;
        alu_wb_valid = 1'b0;
        alu_wb_rd    = '0;
        alu_wb_data  = '0;
        ld_wb_valid  = 1'b0;
        ld_wb_rd     = '0;
        ld_wb_data   = '0;
    endtask

    // One clock cycle: predict, compare mid-cycle, advance model at edge.
    task automatic cycle();
        bit haz, ga, gl;
        logic [31:0] bv;
        haz = m_busy[issue_rs1] | m_busy[issue_rs2]
            | (issue_rd_we & m_busy[issue_rd]);
        if (alu_wb_valid && ld_wb_valid) begin
            ga = m_last;
            gl = !m_last;
        end else begin
            ga = alu_wb_valid;
            gl = ld_wb_valid;
        end
        bv = '0;
        for (int i = 0; i < 32; i++) bv[i] = m_busy[i];
        @(negedge clk);
        chk("issue_ready", issue_ready, !haz);
        chk("alu_wb_ready", alu_wb_ready, ga);
        chk("ld_wb_ready", ld_wb_ready, gl);
        chk("busy_vec", busy_vec, bv);
        chk("stall_count", stall_count, m_stall);
        @(posedge clk);
        while (clr_q.size() > 0 && clr_q[0].cyc == cyc) begin
            m_busy[clr_q[0].rd] = 1'b0;
            void'(clr_q.pop_front());
        end
        if (ga) begin
            sb.push_back('{cyc + 1, alu_wb_rd, alu_wb_data});
            clr_q.push_back('{cyc + 1, alu_wb_rd, alu_wb_data});
            m_last = 1'b0;
        end
        if (gl) begin
            sb.push_back('{cyc + 1, ld_wb_rd, ld_wb_data});
            clr_q.push_back('{cyc + 1, ld_wb_rd, ld_wb_data});
            m_last = 1'b1;
        end
        if (issue_valid && !haz && issue_rd_we && issue_rd != 0)
            m_busy[issue_rd] = 1'b1;
        if (issue_valid && haz && m_stall < 65535)
            m_stall++;
        g_alu = ga;
        g_ld  = gl;
        cyc++;
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        #1;
        chk("rst_rf_we", rf_we, 0);
        chk("rst_busy", busy_vec, 0);
        chk("rst_waddr", rf_waddr, 0);
        chk("rst_wdata", rf_wdata, 0);
        chk("rst_stall", stall_count, 0);
        sb.delete();
        clr_q.delete();
        for (int i = 0; i < 32; i++) m_busy[i] = 1'b0;
        m_last  = 1'b1;
        m_stall = 0;
        @(posedge clk);
        cyc++;
        #1;
        reset = 1'b0;
    endtask

    // Write-port monitor: every cycle the port must match the scoreboard.
    initial begin
        wr_t e;
        forever begin
            @(negedge clk);
            if (sb.size() > 0 && sb[0].cyc == cyc) begin
                e = sb.pop_front();
                chk("rf_we", rf_we, e.rd != 0);
                if (e.rd != 0) begin
                    chk("rf_waddr", rf_waddr, e.rd);
                    chk("rf_wdata", rf_wdata, e.data);
                end
            end else begin
                chk("rf_we_idle", rf_we, 0);
            end
        end
    end

    initial begin
        #1500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        set_idle();
        do_reset();

        // RAW stall, writeback, release two cycles after the grant
        issue_valid = 1'b1;
        issue_rd    = 5'd5;
        issue_rd_we = 1'b1;
        cycle();
        issue_rd_we = 1'b0;
        issue_rd    = 5'd0;
        issue_rs1   = 5'd5;
        repeat (3) cycle();
        chk("busy_x5", busy_vec, 32'h20);
        alu_wb_valid = 1'b1;
        alu_wb_rd    = 5'd5;
        alu_wb_data  = 32'hDEADBEEF;
        cycle();
        alu_wb_valid = 1'b0;
        cycle();
        cycle();
        chk("stall_total", stall_count, 5);
        set_idle();
        cycle();

        // Tie-break alternation from reset: ALU first
        do_reset();
        alu_wb_valid = 1'b1;
        alu_wb_rd    = 5'd3;
        alu_wb_data  = $urandom;
        ld_wb_valid  = 1'b1;
        ld_wb_rd     = 5'd4;
        ld_wb_data   = $urandom;
        for (int k = 0; k < 4; k++) begin
            cycle();
            if (g_alu) alu_wb_data = $urandom;
            if (g_ld)  ld_wb_data  = $urandom;
        end
        set_idle();
        repeat (2) cycle();

        // x0 is never tracked or written
        issue_valid = 1'b1;
        issue_rd    = 5'd0;
        issue_rd_we = 1'b1;
        cycle();
        set_idle();
        alu_wb_valid = 1'b1;
        alu_wb_rd    = 5'd0;
        alu_wb_data  = 32'h12345678;
        cycle();
        set_idle();
        repeat (2) cycle();

        // Reset drops an in-flight write to x7
        issue_valid = 1'b1;
        issue_rd    = 5'd7;
        issue_rd_we = 1'b1;
        cycle();
        set_idle();
        alu_wb_valid = 1'b1;
        alu_wb_rd    = 5'd7;
        alu_wb_data  = 32'hCAFEF00D;
        cycle();
        set_idle();
        do_reset();
        repeat (3) cycle();

        // Stall counter saturation
        issue_valid = 1'b1;
        issue_rd    = 5'd5;
        issue_rd_we = 1'b1;
        cycle();
        issue_rd_we = 1'b0;
        issue_rd    = 5'd0;
        issue_rs1   = 5'd5;
        repeat (70000) cycle();
        chk("stall_sat", stall_count, 16'hFFFF);
        set_idle();
        do_reset();

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            issue_valid = 1'($urandom_range(0, 1));
            issue_rs1   = 5'($urandom_range(0, 7));
            issue_rs2   = 5'($urandom_range(0, 7));
            issue_rd    = 5'($urandom_range(0, 7));
            issue_rd_we = 1'($urandom_range(0, 1));
            if (!alu_wb_valid && $urandom_range(0, 1) == 1) begin
                alu_wb_valid = 1'b1;
                alu_wb_rd    = 5'($urandom_range(0, 7));
                alu_wb_data  = $urandom;
            end
            if (!ld_wb_valid && $urandom_range(0, 1) == 1) begin
                ld_wb_valid = 1'b1;
                ld_wb_rd    = 5'($urandom_range(0, 7));
                ld_wb_data  = $urandom;
            end
            cycle();
            if (g_alu) alu_wb_valid = 1'b0;
            if (g_ld)  ld_wb_valid  = 1'b0;
        end
        set_idle();
        repeat (4) cycle();

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
